ppu_pool_engine: RTL and testbench



---
 rtl/ppu_pool_engine.sv | 257 +++++++++++++++++++++++++
 tb/tb_ppu_pool_engine.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/ppu_pool_engine.sv
// Pooling engine: buffers up to three accumulator rows and emits max or 2x2-average
// pooled rows over a run-time configured window, stride and map geometry.
module ppu_pool_engine #(
  parameter int DATA_W = 16,
  parameter int LANES  = 16,
  parameter int ROW_W  = 8,
  parameter int MAP_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    cfg_mode,
  input  logic [1:0]              cfg_win,
  input  logic [1:0]              cfg_stride,
  input  logic [$clog2(LANES+1)-1:0] cfg_row_len,
  input  logic [ROW_W-1:0]        cfg_rows,
  input  logic [MAP_W-1:0]        cfg_maps,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*DATA_W-1:0] out_data,
  output logic [LANES-1:0]        out_mask,
  output logic [MAP_W-1:0]        out_map_idx,
  output logic                    busy,
  output logic                    done,
  output logic                    cfg_err
);

  localparam int CW = $clog2(LANES + 1);
  localparam int SW = DATA_W + 2;
  // Padded column span so stride-2 windows past the last lane read zeros.
  localparam int XN = 2 * LANES + 1;
  localparam int XW = $clog2(XN);

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_EMIT, S_DRAIN, S_NEXTMAP, S_DONE} state_e;

  state_e                  state_q, state_d;
  logic                    mode_q;
  logic [1:0]              win_q, stride_q;
  logic [CW-1:0]           row_len_q;
  logic [ROW_W-1:0]        rows_q;
  logic [MAP_W-1:0]        maps_q;
  logic [1:0]              rows_held_q, rows_held_d;
  logic [1:0]              rd_ptr_q, rd_ptr_d;
  logic [ROW_W-1:0]        out_row_cnt_q, out_row_cnt_d;
  logic [ROW_W-1:0]        in_row_cnt_q, in_row_cnt_d;
  logic [MAP_W-1:0]        map_idx_q, map_idx_d;
  logic [LANES*DATA_W-1:0] row_buf_q [3];

  logic                    in_ready_q, out_valid_q, busy_q, done_q, cfg_err_q;
  logic [LANES*DATA_W-1:0] out_data_q;
  logic [LANES-1:0]        out_mask_q;
  logic [MAP_W-1:0]        out_map_idx_q;

  logic                    cfg_load, cfg_bad, in_fire, out_fire, load_out, buf_we;
  logic [1:0]              win_eff;
  logic [CW-1:0]           oc;
  logic [ROW_W-1:0]        or_cnt;
  logic [LANES*DATA_W-1:0] pool_data;
  logic [LANES-1:0]        pool_mask;
  logic signed [DATA_W-1:0] win_elem [3][XN];

  function automatic logic [1:0] ptr_add(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
  endfunction

  assign cfg_load = (state_q == S_IDLE) && start;
  assign win_eff  = cfg_load ? cfg_win : win_q;
  assign in_fire  = in_valid && in_ready_q;
  assign out_fire = out_valid_q && out_ready;
  assign buf_we   = (state_q == S_FILL) && in_fire;

  assign cfg_bad = ((cfg_win != 2'd2) && (cfg_win != 2'd3)) ||
                   ((cfg_stride != 2'd1) && (cfg_stride != 2'd2)) ||
                   (cfg_mode && (cfg_win == 2'd3)) ||
                   (cfg_row_len < CW'(cfg_win)) ||
                   (cfg_row_len > CW'(LANES)) ||
                   (cfg_rows < ROW_W'(cfg_win)) ||
                   (cfg_maps == '0);

  // Output geometry; only meaningful once a legal configuration is latched.
  always_comb begin
    oc     = row_len_q - CW'(win_q);
    oc     = ((stride_q == 2'd2) ? (oc >> 1) : oc) + CW'(1);
    or_cnt = rows_q - ROW_W'(win_q);
    or_cnt = ((stride_q == 2'd2) ? (or_cnt >> 1) : or_cnt) + ROW_W'(1);
  end

  // Window rows oldest-first; the slot just past the resident rows is the incoming beat.
  always_comb begin : window_view
    logic [LANES*DATA_W-1:0] src;
    src = '0;
    for (int k = 0; k < 3; k++) begin
      src = '0;
      if (2'(k) < rows_held_q)       src = row_buf_q[ptr_add(rd_ptr_q, 2'(k))];
      else if (2'(k) == rows_held_q) src = in_data;
      for (int c = 0; c < LANES; c++)  win_elem[k][c] = src[c*DATA_W +: DATA_W];
      for (int c = LANES; c < XN; c++) win_elem[k][c] = '0;
    end
  end

  always_comb begin : pool_calc
    logic signed [DATA_W-1:0] mx, e;
    logic signed [SW-1:0]     sum;
    int                       st;
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    pool_data = '0;
    pool_mask = '0;
    mx        = '0;
    e         = '0;
    sum       = '0;
    st        = (stride_q == 2'd2) ? 2 : 1;
    for (int j = 0; j < LANES; j++) begin
      mx  = {1'b1, {(DATA_W-1){1'b0}}};
      sum = '0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          e = win_elem[r][XW'(j * st + c)];
          if ((2'(r) < win_q) && (2'(c) < win_q) && (e > mx)) mx = e;
          if ((r < 2) && (c < 2)) sum = sum + SW'(e);
        end
      end
      if (j < int'(oc)) begin
        pool_mask[j] = 1'b1;
        pool_data[j*DATA_W +: DATA_W] = mode_q ? DATA_W'(sum >>> 2) : mx;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    rows_held_d   = rows_held_q;
    rd_ptr_d      = rd_ptr_q;
    out_row_cnt_d = out_row_cnt_q;
    in_row_cnt_d  = in_row_cnt_q;
    map_idx_d     = map_idx_q;
    load_out      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          rows_held_d   = '0;
          rd_ptr_d      = '0;
          out_row_cnt_d = '0;
          in_row_cnt_d  = '0;
          map_idx_d     = '0;
          state_d       = cfg_bad ? S_DONE : S_FILL;
        end
      end
      S_FILL: begin
        if (in_fire) begin
          rows_held_d  = rows_held_q + 2'd1;
          in_row_cnt_d = in_row_cnt_q + ROW_W'(1);
          if (rows_held_q + 2'd1 == win_q) begin
            load_out = 1'b1;
            state_d  = S_EMIT;
          end
        end
      end
      S_EMIT: begin
        if (out_fire) begin
          rows_held_d   = rows_held_q - stride_q;
          rd_ptr_d      = ptr_add(rd_ptr_q, stride_q);
          out_row_cnt_d = out_row_cnt_q + ROW_W'(1);
          if (out_row_cnt_q + ROW_W'(1) < or_cnt) state_d = S_FILL;
          else if (in_row_cnt_q < rows_q)         state_d = S_DRAIN;
          else                                    state_d = S_NEXTMAP;
        end
      end
      S_DRAIN: begin
        if (in_fire) begin
          in_row_cnt_d = in_row_cnt_q + ROW_W'(1);
          if (in_row_cnt_q + ROW_W'(1) == rows_q) state_d = S_NEXTMAP;
        end
      end
      S_NEXTMAP: begin
        rows_held_d   = '0;
        rd_ptr_d      = '0;
        out_row_cnt_d = '0;
        in_row_cnt_d  = '0;
        map_idx_d     = map_idx_q + MAP_W'(1);
        state_d       = (map_idx_d == maps_q) ? S_DONE : S_FILL;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      mode_q        <= 1'b0;
      win_q         <= '0;
      stride_q      <= '0;
      row_len_q     <= '0;
      rows_q        <= '0;
      maps_q        <= '0;
      rows_held_q   <= '0;
      rd_ptr_q      <= '0;
      out_row_cnt_q <= '0;
      in_row_cnt_q  <= '0;
      map_idx_q     <= '0;
      in_ready_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      cfg_err_q     <= 1'b0;
      out_data_q    <= '0;
      out_mask_q    <= '0;
      out_map_idx_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q       <= state_d;
      rows_held_q   <= rows_held_d;
      rd_ptr_q      <= rd_ptr_d;
      out_row_cnt_q <= out_row_cnt_d;
      in_row_cnt_q  <= in_row_cnt_d;
      map_idx_q     <= map_idx_d;
      in_ready_q    <= ((state_d == S_FILL) && (rows_held_d < win_eff)) || (state_d == S_DRAIN);
      out_valid_q   <= (state_d == S_EMIT);
      busy_q        <= (state_d != S_IDLE) && (state_d != S_DONE);
      done_q        <= (state_d == S_DONE);
      if (cfg_load) begin
        mode_q    <= cfg_mode;
        win_q     <= cfg_win;
        stride_q  <= cfg_stride;
        row_len_q <= cfg_row_len;
        rows_q    <= cfg_rows;
        maps_q    <= cfg_maps;
        cfg_err_q <= cfg_bad;
      end
      if (load_out) begin
        out_data_q    <= pool_data;
        out_mask_q    <= pool_mask;
        out_map_idx_q <= map_idx_q;
      end
    end
  end

  // NOTE: row storage is not reset; rows_held gates every read, so stale contents are never used.
  always_ff @(posedge clk) begin
    if (buf_we) row_buf_q[ptr_add(rd_ptr_q, rows_held_q)] <= in_data;
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_mask    = out_mask_q;
  assign out_map_idx = out_map_idx_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_ppu_pool_engine.sv
// Directed bench for ppu_pool_engine with LANES=8: max/avg pooling, drain,
// multi-map, backpressure, illegal configuration and mid-job reset.
module tb_ppu_pool_engine;

  localparam int DW = 16;
  localparam int L  = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          cfg_mode = 1'b0;
  logic [1:0]    cfg_win = '0, cfg_stride = '0;
  logic [3:0]    cfg_row_len = '0;
  logic [7:0]    cfg_rows = '0, cfg_maps = '0;
  logic          in_valid = 1'b0, out_ready = 1'b0;
  logic [L*DW-1:0] in_data = '0;
  logic          in_ready, out_valid, busy, done, cfg_err;
  logic [L*DW-1:0] out_data;
  logic [L-1:0]  out_mask;
  logic [7:0]    out_map_idx;

  int total = 0;
  int bad   = 0;

  ppu_pool_engine #(.DATA_W(DW), .LANES(L), .ROW_W(8), .MAP_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_mode(cfg_mode), .cfg_win(cfg_win),
    .cfg_stride(cfg_stride), .cfg_row_len(cfg_row_len), .cfg_rows(cfg_rows),
    .cfg_maps(cfg_maps), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_mask(out_mask), .out_map_idx(out_map_idx), .busy(busy), .done(done),
    .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [L*DW-1:0] mk_row(input int base);
    logic [L*DW-1:0] v;
    for (int c = 0; c < L; c++) v[c*DW +: DW] = 16'(base + c);
    return v;
  endfunction

  task automatic do_start(input logic mode, input logic [1:0] win, input logic [1:0] stride,
                          input logic [3:0] rl, input logic [7:0] rows, input logic [7:0] maps);
    @(negedge clk);
    cfg_mode = mode; cfg_win = win; cfg_stride = stride;
    cfg_row_len = rl; cfg_rows = rows; cfg_maps = maps;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_row(input string tag, input logic [L*DW-1:0] vec);
    int n;
    n = 0;
    in_data  = vec;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    check({tag, "_accept"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Expected lane j is base+step*j for j < n, zero elsewhere.
  task automatic recv_row(input string tag, input int base, input int step, input int n,
                          input logic [7:0] mask, input logic [7:0] map, input int hold);
    int w;
    logic [L*DW-1:0] snap;
    logic stable;
    w = 0;
    while (!out_valid && w < 100) begin @(negedge clk); w++; end
    check({tag, "_latency"}, 32'(w), 32'd0);
    if (hold > 0) begin
      snap   = out_data;
      stable = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        if (out_data !== snap || in_ready !== 1'b0 || out_valid !== 1'b1) stable = 1'b0;
      end
      check({tag, "_bp_hold"}, 32'(stable), 32'd1);
    end
    for (int j = 0; j < L; j++) begin
      int ev;
      ev = (j < n) ? base + step * j : 0;
      check($sformatf("%s_lane%0d", tag, j), {16'h0, out_data[j*DW +: DW]}, {16'h0, 16'(ev)});
    end
    check({tag, "_mask"}, 32'(out_mask), 32'(mask));
    check({tag, "_map"}, 32'(out_map_idx), 32'(map));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!done && n < 50) begin @(negedge clk); n++; end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  // 2x2 stride-2 job over 4 rows of r*8+c.
  task automatic run_basic(input string tag, input logic mode);
    do_start(mode, 2'd2, 2'd2, 4'd8, 8'd4, 8'd1);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    send_row({tag, "_r0"}, mk_row(0));
    send_row({tag, "_r1"}, mk_row(8));
    recv_row({tag, "_o0"}, mode ? 4 : 9, 2, 4, 8'h0F, 8'd0, 0);
    send_row({tag, "_r2"}, mk_row(16));
    send_row({tag, "_r3"}, mk_row(24));
    recv_row({tag, "_o1"}, mode ? 20 : 25, 2, 4, 8'h0F, 8'd0, 0);
    wait_done(tag);
  endtask

  initial begin
    logic [L*DW-1:0] v;
    logic seen;

    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_cfg_err", 32'(cfg_err), 32'd0);
    check("rst_out_mask", 32'(out_mask), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_basic("max22", 1'b0);
    run_basic("avg22", 1'b1);

    // Signed average of {-1,-2,-2,-2} floors to -2.
    do_start(1'b1, 2'd2, 2'd2, 4'd2, 8'd2, 8'd1);
    v = '0; v[0 +: DW] = 16'hFFFF; v[DW +: DW] = 16'hFFFE;
    send_row("savg_r0", v);
    v = '0; v[0 +: DW] = 16'hFFFE; v[DW +: DW] = 16'hFFFE;
    send_row("savg_r1", v);
    recv_row("savg_o0", -2, 0, 1, 8'h01, 8'd0, 0);
    wait_done("savg");

    // 3x3 stride-1 max over 5 columns.
    do_start(1'b0, 2'd3, 2'd1, 4'd5, 8'd3, 8'd1);
    send_row("max33_r0", mk_row(0));
    send_row("max33_r1", mk_row(8));
    send_row("max33_r2", mk_row(16));
    recv_row("max33_o0", 18, 1, 3, 8'h07, 8'd0, 0);
    wait_done("max33");

    // Two maps of five rows: fifth row of each is drained; first output back-pressured.
    do_start(1'b0, 2'd2, 2'd2, 4'd8, 8'd5, 8'd2);
    for (int m = 0; m < 2; m++) begin
      send_row($sformatf("mm%0d_r0", m), mk_row(m * 64));
      send_row($sformatf("mm%0d_r1", m), mk_row(m * 64 + 8));
      recv_row($sformatf("mm%0d_o0", m), m * 64 + 9, 2, 4, 8'h0F, 8'(m), (m == 0) ? 10 : 0);
      send_row($sformatf("mm%0d_r2", m), mk_row(m * 64 + 16));
      send_row($sformatf("mm%0d_r3", m), mk_row(m * 64 + 24));
      recv_row($sformatf("mm%0d_o1", m), m * 64 + 25, 2, 4, 8'h0F, 8'(m), 0);
      check($sformatf("mm%0d_drain_ready", m), 32'(in_ready), 32'd1);
      send_row($sformatf("mm%0d_r4", m), mk_row(m * 64 + 32));
    end
    wait_done("multimap");

    // Average with a 3x3 window is illegal.
    do_start(1'b1, 2'd3, 2'd1, 4'd8, 8'd4, 8'd1);
    check("err_done", 32'(done), 32'd1);
    check("err_flag", 32'(cfg_err), 32'd1);
    check("err_busy", 32'(busy), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("err_no_out", 32'(seen), 32'd0);
    check("err_sticky", 32'(cfg_err), 32'd1);

    // Reset in the middle of filling, then a clean job.
    do_start(1'b0, 2'd2, 2'd2, 4'd8, 8'd4, 8'd1);
    check("rj_err_cleared", 32'(cfg_err), 32'd0);
    send_row("rj_r0", mk_row(0));
    rst_n = 1'b0;
    #1;
    check("rj_busy", 32'(busy), 32'd0);
    check("rj_in_ready", 32'(in_ready), 32'd0);
    check("rj_out_valid", 32'(out_valid), 32'd0);
    check("rj_data", 32'(|out_data), 32'd0);
    check("rj_mask", 32'(out_mask), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    check("rj_quiet", 32'(seen), 32'd0);
    run_basic("post_rst", 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
